// File: rtl/proc_hazard_ctrl.sv
// Hazard and writeback control for the TinyRV1 5-stage pipeline.
// Decodes the D-stage instruction and tracks the destination registers
// of the instructions in X, M and W. From these it produces operand
// bypass selects, the load-use stall and the W-stage register-file write.
module proc_hazard_ctrl #(
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inst_val_D,
  input  logic [31:0]              inst_D,
  input  logic                     squash_D,
  output logic                     stall_D,
  output logic [1:0]               op1_byp_sel_D,
  output logic [1:0]               op2_byp_sel_D,
  output logic                     rf_wen_W,
  output logic [$clog2(NREGS)-1:0] rf_waddr_W,
  output logic                     illegal_D,
  output logic                     val_X
);

  localparam int AW = $clog2(NREGS);

  // In-flight scoreboard. Only X needs the load flag: once a load reaches
  // M, the M result already carries the memory data and can be bypassed.
  logic          r_val_X, r_wen_X, r_load_X;
  logic [AW-1:0] r_rd_X;
  logic          r_val_M, r_wen_M;
  logic [AW-1:0] r_rd_M;
  logic          r_val_W, r_wen_W;
  logic [AW-1:0] r_rd_W;

  // Decoded D-stage fields
  logic [6:0]    w_opcode;
  logic [6:0]    w_funct7;
  logic [AW-1:0] w_rd;
  logic [AW-1:0] w_rs [2];
  logic [1:0]    w_reads;
  logic          w_writes;
  logic          w_load;
  logic          w_legal;
  logic          w_wen_D;
  logic          w_accept;
  logic          w_unused_funct3;

  // Per-operand hazard detection
  logic [1:0]    w_active;
  logic [1:0]    w_hit_x, w_hit_m, w_hit_w;
  logic [1:0]    w_luse;
  logic [1:0]    w_sel [2];

  assign w_opcode        = inst_D[6:0];
  assign w_funct7        = inst_D[31:25];
  assign w_rd            = inst_D[7 +: AW];
  assign w_rs[0]         = inst_D[15 +: AW];
  assign w_rs[1]         = inst_D[20 +: AW];
  // funct3 does not distinguish any of the supported instructions
  assign w_unused_funct3 = ^inst_D[14:12];

  // Opcode decode: which operands are read, whether rd is written, load flag
  always_comb begin
    w_reads  = 2'b00;
    w_writes = 1'b0;
    w_load   = 1'b0;
    w_legal  = 1'b1;
    case (w_opcode)
      7'b0110011: begin // add / mul
        if (w_funct7 == 7'b0000000 || w_funct7 == 7'b0000001) begin
          w_reads  = 2'b11;
          w_writes = 1'b1;
        end else begin
          w_legal  = 1'b0;
        end
      end
      7'b0010011: begin // addi
        w_reads  = 2'b01;
        w_writes = 1'b1;
      end
      7'b0000011: begin // lw
        w_reads  = 2'b01;
        w_writes = 1'b1;
        w_load   = 1'b1;
      end
      7'b0100011: w_reads  = 2'b11; // sw
      7'b1101111: w_writes = 1'b1;  // jal
      7'b1100111: w_reads  = 2'b01; // jr
      7'b1100011: w_reads  = 2'b11; // bne
      default:    w_legal  = 1'b0;
    endcase
  end

  // Writes to x0 are discarded, so they never become bypass sources
  assign w_wen_D   = w_writes & (w_rd != '0);
  assign illegal_D = inst_val_D & ~w_legal;

  // Same bypass/hazard logic for both source operands; X has priority
  // over M over W so the youngest producer always wins.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_operand
      assign w_active[gi] = inst_val_D & w_reads[gi] & (w_rs[gi] != '0);
      assign w_hit_x[gi]  = w_active[gi] & r_val_X & r_wen_X & (r_rd_X == w_rs[gi]);
      assign w_hit_m[gi]  = w_active[gi] & r_val_M & r_wen_M & (r_rd_M == w_rs[gi]);
      assign w_hit_w[gi]  = w_active[gi] & r_val_W & r_wen_W & (r_rd_W == w_rs[gi]);
      assign w_sel[gi]    = w_hit_x[gi] ? 2'd1 :
                            w_hit_m[gi] ? 2'd2 :
                            w_hit_w[gi] ? 2'd3 : 2'd0;
      // A load in X has no data yet; the consumer must wait one cycle
      assign w_luse[gi]   = w_hit_x[gi] & r_load_X;
    end
  endgenerate

  assign op1_byp_sel_D = w_sel[0];
  assign op2_byp_sel_D = w_sel[1];

  // Squash overrides stall: a killed instruction never waits
  assign stall_D  = ~squash_D & (|w_luse);
  assign w_accept = inst_val_D & ~squash_D & ~stall_D;

  // Pipeline advance: X takes D or a bubble, M and W always shift
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_val_X  <= 1'b0;
      r_wen_X  <= 1'b0;
      r_load_X <= 1'b0;
      r_rd_X   <= '0;
      r_val_M  <= 1'b0;
      r_wen_M  <= 1'b0;
      r_rd_M   <= '0;
      r_val_W  <= 1'b0;
      r_wen_W  <= 1'b0;
      r_rd_W   <= '0;
    end else begin
      r_val_X  <= w_accept;
      r_wen_X  <= w_accept & w_wen_D;
      r_load_X <= w_accept & w_load;
      r_rd_X   <= w_accept ? w_rd : '0;
      r_val_M  <= r_val_X;
      r_wen_M  <= r_wen_X;
      r_rd_M   <= r_rd_X;
      r_val_W  <= r_val_M;
      r_wen_W  <= r_wen_M;
      r_rd_W   <= r_rd_M;
    end
  end

  assign rf_wen_W   = r_val_W & r_wen_W;
  assign rf_waddr_W = rf_wen_W ? r_rd_W : '0;
  assign val_X      = r_val_X;

endmodule

// File: tb/tb_proc_hazard_ctrl.sv
// Self-checking bench for proc_hazard_ctrl: a per-cycle vector table for
// the D-stage outputs, a writeback scoreboard queue, and a hand-written
// asynchronous reset sequence.
module tb_proc_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_val_D = 1'b0;
  logic [31:0] inst_D = 32'h0;
  logic        squash_D = 1'b0;
  logic        stall_D;
  logic [1:0]  op1_byp_sel_D, op2_byp_sel_D;
  logic        rf_wen_W;
  logic [4:0]  rf_waddr_W;
  logic        illegal_D;
  logic        val_X;

  proc_hazard_ctrl #(.NREGS(32)) dut (
    .clk(clk), .rst(rst), .inst_val_D(inst_val_D), .inst_D(inst_D),
    .squash_D(squash_D), .stall_D(stall_D), .op1_byp_sel_D(op1_byp_sel_D),
    .op2_byp_sel_D(op2_byp_sel_D), .rf_wen_W(rf_wen_W), .rf_waddr_W(rf_waddr_W),
    .illegal_D(illegal_D), .val_X(val_X)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] NOP    = 32'h00000013; // addi x0,x0,0
  localparam logic [31:0] ADDI1  = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] ADD312 = 32'h002081B3; // add x3,x1,x2
  localparam logic [31:0] LW2    = 32'h0000A103; // lw x2,0(x1)
  localparam logic [31:0] ADD322 = 32'h002101B3; // add x3,x2,x2
  localparam logic [31:0] ADDIX0 = 32'h00500013; // addi x0,x0,5
  localparam logic [31:0] ADD400 = 32'h00000233; // add x4,x0,x0
  localparam logic [31:0] ADD411 = 32'h00108233; // add x4,x1,x1
  localparam logic [31:0] ILL    = 32'hFFFFFFFF;

  typedef struct {
    logic        val;
    logic [31:0] inst;
    logic        sq;
    logic        stall;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic        ill;
    logic        vx;
    logic [4:0]  wb;   // rd expected to be written back (0 = none)
  } vec_t;

  typedef struct {
    logic [4:0] rd;
    int         due;
  } wb_t;

  localparam int NV = 34;
  vec_t vecs [NV];
  wb_t  sbq [$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(logic v, logic [31:0] i, logic sq, logic st,
                              logic [1:0] a, logic [1:0] b, logic il,
                              logic vx, logic [4:0] wb);
    vec_t r;
    r.val = v; r.inst = i; r.sq = sq; r.stall = st; r.s1 = a; r.s2 = b;
    r.ill = il; r.vx = vx; r.wb = wb;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Writeback monitor: every write must match the oldest expected one,
  // both in address and in the cycle it appears.
  always @(negedge clk) begin
    if (rst) begin
      if (rf_wen_W) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got waddr %0d expected no write (cycle %0d)",
                   rf_waddr_W, cyc);
        end else begin
          wb_t e;
          e = sbq.pop_front();
          chk("wb_addr", 32'(rf_waddr_W), 32'(e.rd));
          chk("wb_cycle", cyc, e.due);
          $display("wb x%0d at cycle %0d", rf_waddr_W, cyc);
        end
      end else begin
        chk("waddr_idle", 32'(rf_waddr_W), 32'd0);
      end
    end
  end

  initial begin
    //                val   inst    sq   stall s1 s2 ill  vx  wb
    vecs[0]  = mk(1, ADDI1,  0, 0, 0, 0, 0, 0, 1);
    vecs[1]  = mk(1, ADD312, 0, 0, 1, 0, 0, 1, 3); // distance 1
    vecs[2]  = mk(1, ADDI1,  0, 0, 0, 0, 0, 1, 1);
    vecs[3]  = mk(1, NOP,    0, 0, 0, 0, 0, 1, 0);
    vecs[4]  = mk(1, ADD312, 0, 0, 2, 0, 0, 1, 3); // distance 2
    vecs[5]  = mk(1, ADDI1,  0, 0, 0, 0, 0, 1, 1);
    vecs[6]  = mk(1, NOP,    0, 0, 0, 0, 0, 1, 0);
    vecs[7]  = mk(1, NOP,    0, 0, 0, 0, 0, 1, 0);
    vecs[8]  = mk(1, ADD312, 0, 0, 3, 0, 0, 1, 3); // distance 3
    vecs[9]  = mk(1, NOP,    0, 0, 0, 0, 0, 1, 0);
    vecs[10] = mk(1, LW2,    0, 0, 0, 0, 0, 1, 2);
    vecs[11] = mk(1, ADD322, 0, 1, 1, 1, 0, 1, 0); // load-use stall
    vecs[12] = mk(1, ADD322, 0, 0, 2, 2, 0, 0, 3); // load now in M
    vecs[13] = mk(1, NOP,    0, 0, 0, 0, 0, 1, 0);
    vecs[14] = mk(1, ADDIX0, 0, 0, 0, 0, 0, 1, 0); // write to x0
    vecs[15] = mk(1, ADD400, 0, 0, 0, 0, 0, 1, 4);
    vecs[16] = mk(1, NOP,    0, 0, 0, 0, 0, 1, 0);
    vecs[17] = mk(1, LW2,    0, 0, 0, 0, 0, 1, 2);
    vecs[18] = mk(1, ADD322, 1, 0, 1, 1, 0, 1, 0); // squash beats stall
    vecs[19] = mk(1, NOP,    0, 0, 0, 0, 0, 0, 0);
    vecs[20] = mk(1, ADDI1,  0, 0, 0, 0, 0, 1, 1);
    vecs[21] = mk(1, ADDI1,  0, 0, 0, 0, 0, 1, 1);
    vecs[22] = mk(1, ADD411, 0, 0, 1, 1, 0, 1, 4); // X beats M
    vecs[23] = mk(1, ILL,    0, 0, 0, 0, 1, 1, 0);
    vecs[24] = mk(1, NOP,    0, 0, 0, 0, 0, 1, 0);
    vecs[25] = mk(0, ADD411, 0, 0, 0, 0, 0, 1, 0); // not valid
    vecs[26] = mk(0, ILL,    0, 0, 0, 0, 0, 0, 0);
    vecs[27] = mk(1, ADDI1,  0, 0, 0, 0, 0, 0, 1);
    vecs[28] = mk(1, NOP,    0, 0, 0, 0, 0, 1, 0);
    vecs[29] = mk(1, ADDI1,  0, 0, 0, 0, 0, 1, 1);
    vecs[30] = mk(1, ADD411, 0, 0, 1, 1, 0, 1, 4); // X and W both x1
    vecs[31] = mk(1, NOP,    0, 0, 0, 0, 0, 1, 0);
    vecs[32] = mk(1, NOP,    0, 0, 0, 0, 0, 1, 0);
    vecs[33] = mk(1, NOP,    0, 0, 0, 0, 0, 1, 0);

    // Held in reset: everything idle
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(stall_D), 32'd0);
    chk("rst_sel1", 32'(op1_byp_sel_D), 32'd0);
    chk("rst_wen", 32'(rf_wen_W), 32'd0);
    chk("rst_valx", 32'(val_X), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      inst_val_D = vecs[i].val;
      inst_D     = vecs[i].inst;
      squash_D   = vecs[i].sq;
      if (vecs[i].wb != 5'd0) begin
        wb_t e;
        e.rd  = vecs[i].wb;
        e.due = cyc + 3;
        sbq.push_back(e);
      end
      #1;
      $display("vec %0d val=%0b inst=%08h sq=%0b -> stall=%0b sel=%0d/%0d ill=%0b valX=%0b",
               i, inst_val_D, inst_D, squash_D, stall_D, op1_byp_sel_D,
               op2_byp_sel_D, illegal_D, val_X);
      chk($sformatf("v%0d_stall", i), 32'(stall_D), 32'(vecs[i].stall));
      chk($sformatf("v%0d_sel1", i), 32'(op1_byp_sel_D), 32'(vecs[i].s1));
      chk($sformatf("v%0d_sel2", i), 32'(op2_byp_sel_D), 32'(vecs[i].s2));
      chk($sformatf("v%0d_illegal", i), 32'(illegal_D), 32'(vecs[i].ill));
      chk($sformatf("v%0d_valx", i), 32'(val_X), 32'(vecs[i].vx));
    end

    // Drain and confirm every expected write appeared
    @(posedge clk);
    #1;
    inst_val_D = 1'b0;
    squash_D   = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("sb_drained", sbq.size(), 0);

    // Asynchronous reset mid-stream: addi x1 reaches W while lw x2 sits in
    // X and add x3,x2,x2 waits in D. None of these are expected to write.
    @(posedge clk); #1; inst_val_D = 1'b1; inst_D = ADDI1;
    @(posedge clk); #1; inst_D = NOP;
    @(posedge clk); #1; inst_D = LW2;
    @(posedge clk); #1; inst_D = ADD322;
    #1;
    $display("pre-reset stall=%0b sel=%0d/%0d wen=%0b", stall_D, op1_byp_sel_D,
             op2_byp_sel_D, rf_wen_W);
    chk("pre_rst_stall", 32'(stall_D), 32'd1);
    chk("pre_rst_sel1", 32'(op1_byp_sel_D), 32'd1);
    chk("pre_rst_wen", 32'(rf_wen_W), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    $display("in-reset stall=%0b sel=%0d/%0d wen=%0b", stall_D, op1_byp_sel_D,
             op2_byp_sel_D, rf_wen_W);
    chk("arst_stall", 32'(stall_D), 32'd0);
    chk("arst_sel1", 32'(op1_byp_sel_D), 32'd0);
    chk("arst_sel2", 32'(op2_byp_sel_D), 32'd0);
    chk("arst_wen", 32'(rf_wen_W), 32'd0);
    chk("arst_waddr", 32'(rf_waddr_W), 32'd0);
    chk("arst_valx", 32'(val_X), 32'd0);
    inst_D = ILL;
    #1;
    chk("arst_illegal", 32'(illegal_D), 32'd1);
    inst_val_D = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    // Any write now is flagged by the monitor as unexpected
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_valx", 32'(val_X), 32'd0);
    chk("post_rst_sb", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/proc_hazard_ctrl.md
Name: proc_hazard_ctrl

Overview:
- Control-side hazard and writeback tracker for the 5-stage TinyRV1 pipeline (F/D/X/M/W).
- Sits upstream of the processor datapath. Drives the datapath's operand bypass selects (op1/op2, D stage), the D-stage stall, and the W-stage register-file write enable/address.
- Decodes the instruction held in D and keeps a small scoreboard of in-flight destination registers for X, M and W.

Parameters:
- NREGS, 32, number of architectural registers; x0 is hardwired zero and never tracked.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- inst_val_D  input  1  D stage holds a valid instruction
- inst_D  input  32  instruction in D (datapath IR)
- squash_D  input  1  kill the D instruction (redirect resolved downstream)
- stall_D  output  1  hold F/D; insert bubble into X
- op1_byp_sel_D  output  2  0=regfile, 1=X result, 2=M result, 3=W result
- op2_byp_sel_D  output  2  same encoding for rs2
- rf_wen_W  output  1  regfile write enable
- rf_waddr_W  output  5  regfile write address
- illegal_D  output  1  valid D instruction with unsupported opcode
- val_X  output  1  X stage holds a live instruction (debug/trace)

Behaviour:
- Decode, combinational on inst_D, RISC-V base encodings:
  - OP 0110011: add when funct7=0000000, mul when funct7=0000001. Reads rs1 and rs2, writes rd.
  - OP-IMM 0010011 (addi): reads rs1, writes rd.
  - LOAD 0000011 (lw): reads rs1, writes rd, is_load=1.
  - STORE 0100011 (sw): reads rs1 and rs2, no write.
  - JAL 1101111: writes rd.
  - JALR 1100111 (jr): reads rs1.
  - BRANCH 1100011 (bne): reads rs1 and rs2.
  - Any other opcode, or OP with another funct7: no reads, no write; illegal_D=inst_val_D.
  - A write is only effective when rd!=0.
- Scoreboard: per stage S in {X,M,W} hold val_S, wen_S, rd_S[4:0] and load_S.
- Every clock edge:
  - M<=X and W<=M unconditionally.
  - X captures the decoded D info when inst_val_D & !squash_D & !stall_D; otherwise X gets a bubble (val_X=0, wen_X=0).
- Bypass select for rs1 (rs2 is identical):
  - Operand not read, rs==0, or inst_val_D=0: sel=0.
  - Else, with priority X > M > W:
    - 1 if val_X & wen_X & rd_X==rs
    - 2 if val_M & wen_M & rd_M==rs
    - 3 if val_W & wen_W & rd_W==rs
    - else 0.
  - Selects are computed even while stalling or squashing; the datapath ignores them because X receives a bubble.
- Load-use: a matching X-stage producer with load_X=1 cannot be bypassed, because its data is not ready until M.
  - stall_D = inst_val_D & !squash_D & (read operand matches rd_X with val_X & wen_X & load_X).
  - Loads in M bypass via sel=2, since the M result includes memory read data.
- Squash has priority over stall: squash_D=1 forces stall_D=0 and a bubble into X.
- Writeback outputs:
  - rf_wen_W = val_W & wen_W.
  - rf_waddr_W = rd_W when rf_wen_W, else 0.
- Latency: an instruction accepted from D at edge N asserts rf_wen_W during cycle N+2, i.e. after the edges X->M and M->W.
- Reset (rst=0), asynchronous:
  - Clears val/wen/rd/load in all stages immediately.
  - Outputs go to 0 without waiting for a clock edge: stall_D=0, both bypass selects=0, rf_wen_W=0, rf_waddr_W=0, val_X=0. illegal_D remains combinational on its inputs.
  - Reset mid-operation discards all in-flight instructions; no write is issued for them after release.
- Simultaneous producer in X and W for the same rs: select 1. An instruction whose rs1==rs2 gets identical selects on both outputs.

Test Plan:
- Async reset: run a stream, drop rst between edges -> rf_wen_W, stall_D and both selects go to 0 within the same cycle; after release, no write occurs for the pre-reset instructions.
- Distance bypass: addi x1,x0,5 (0x00500093), then add x3,x1,x2 (0x002081B3) one, two and three cycles later (nops between) -> op1_byp_sel_D=1, 2, 3 respectively; op2_byp_sel_D=0; rf_wen_W=1 with rf_waddr_W=1 exactly two cycles after addi leaves D.
- Load-use: lw x2,0(x1) (0x0000A103), then add x3,x2,x2 (0x002101B3) -> stall_D=1 for exactly one cycle; next cycle stall_D=0 and both selects=2; rf_waddr_W=2 and then 3 on consecutive write cycles.
- x0: addi x0,x0,5 (0x00500013), then add x4,x0,x0 (0x00000233) -> both selects 0, stall_D=0, rf_wen_W never asserted for the addi.
- Squash priority: lw x2 in X with D=add x3,x2,x2 and squash_D=1 -> stall_D=0, val_X=0 next cycle, no write to x3 ever issued.
- Priority and illegal: addi x1,x0,5 twice back-to-back, then add x4,x1,x1 (0x00108233) -> both selects=1 (X wins over M); inst_D=0xFFFFFFFF valid -> illegal_D=1, selects 0, no write.
